// File: rtl/aes_dpc_mk.sv
// aes_dpc_mk: iterative AES round datapath, one round per cycle, per-block key
// length and direction, shared external S-box, and a small output FIFO.
module aes_dpc_mk #(
  parameter int         OUT_DEPTH = 2,
  parameter logic [2:0] KLEN_EN   = 3'b111
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flag,
  input  logic [1:0]    i_klen,
  input  logic [1919:0] i_keyex,
  input  logic [127:0]  i_din,
  input  logic          i_din_valid,
  output logic          o_din_ready,
  output logic [127:0]  o_dout,
  output logic          o_dout_valid,
  input  logic          i_dout_ready,
  output logic          o_err,
  output logic          o_busy,
  output logic [127:0]  o_sbox_din,
  output logic          o_sbox_inv,
  input  logic [127:0]  i_sbox_dout
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUT_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUT_DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  // GF(2^8) multiply by x
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (covers 1,2,3,9,11,13,14)
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] p;
    logic [7:0] a;
    p = 8'h00;
    a = b;
    for (int i = 0; i < 4; i++) begin
      p = m[i] ? (p ^ a) : p;
      a = xt(a);
    end
    return p;
  endfunction

  // MixColumns (inv=0) or InvMixColumns (inv=1) as a circulant matrix per column
  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [15:0]  coef;
    logic [7:0]   acc;
    logic [127:0] o;
    coef = inv ? {4'd14, 4'd11, 4'd13, 4'd9} : {4'd2, 4'd3, 4'd1, 4'd1};
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(s[127-32*c-8*k -: 8], coef[15-4*((k-r+4)%4) -: 4]);
        end
        o[127-32*c-8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  // ShiftRows (inv=0) or InvShiftRows (inv=1); byte (col c,row r) at [127-32c-8r]
  function automatic logic [127:0] shift(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int src;
    o = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127-32*c-8*r -: 8] = s[127-32*src-8*r -: 8];
      end
    end
    return o;
  endfunction

  // Round key j out of the packed schedule, RK[0] in the top 128 bits
  function automatic logic [127:0] rk(input logic [1919:0] kx, input logic [3:0] j);
    int base;
    base = 1919 - 128 * int'(j);
    return kx[base -: 128];
  endfunction

  fsm_t           cur;
  fsm_t           nxt;
  logic [127:0]   state;
  logic [3:0]     rnd;
  logic [3:0]     nr;
  logic [3:0]     nr_in;
  logic           dec;
  logic           err;
  logic           klen_ok;
  logic           accept;
  logic           last;
  logic           pop;
  logic [127:0]   mid;
  logic [127:0]   fin;
  logic [127:0]   load;
  logic [127:0]   mem [OUT_DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [CW-1:0]  count;

  // decode the requested key length into round count and support flag
  always_comb begin
    nr_in   = 4'd10;
    klen_ok = 1'b0;
    case (i_klen)
      2'd0:    begin nr_in = 4'd10; klen_ok = KLEN_EN[0]; end
      2'd1:    begin nr_in = 4'd12; klen_ok = KLEN_EN[1]; end
      2'd2:    begin nr_in = 4'd14; klen_ok = KLEN_EN[2]; end
      default: begin nr_in = 4'd10; klen_ok = 1'b0;       end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // FSM next state: a supported accept starts the rounds, the final round ends them
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    nxt = (accept && klen_ok) ? RUN : IDLE;
      RUN:     nxt = last ? IDLE : RUN;
      default: nxt = IDLE;
    endcase
  end

  // FSM and FIFO outputs
  always_comb begin
    o_din_ready  = (cur == IDLE) && (count < FULL_CNT);
    o_busy       = (cur == RUN);
    o_sbox_din   = shift(state, dec);
    o_sbox_inv   = dec;
    o_dout_valid = (count != {CW{1'b0}});
    o_dout       = mem[rptr];
    o_err        = err;
    accept       = i_din_valid && o_din_ready;
    pop          = o_dout_valid && i_dout_ready;
  end

  // round arithmetic around the external S-box response
  always_comb begin
    last = (cur == RUN) && (rnd == nr);
    if (dec) begin
      mid = mix(i_sbox_dout ^ rk(i_keyex, nr - rnd), 1'b1);
      fin = i_sbox_dout ^ rk(i_keyex, 4'd0);
    end else begin
      mid = mix(i_sbox_dout, 1'b0) ^ rk(i_keyex, rnd);
      fin = i_sbox_dout ^ rk(i_keyex, nr);
    end
    if (i_flag) begin
      load = i_din ^ rk(i_keyex, 4'd0);
    end else begin
      load = i_din ^ rk(i_keyex, nr_in);
    end
  end

  // block state, round counter, latched direction/length and error pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= 128'd0;
      rnd   <= 4'd0;
      nr    <= 4'd0;
      dec   <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= accept && !klen_ok;
      if (accept && klen_ok) begin
        state <= load;
        rnd   <= 4'd1;
        nr    <= nr_in;
        dec   <= !i_flag;
      end else if ((cur == RUN) && !last) begin
        state <= mid;
        rnd   <= rnd + 4'd1;
      end
    end
  end

  // circular output FIFO; space was reserved at accept so a push never overflows
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr  <= {PW{1'b0}};
      rptr  <= {PW{1'b0}};
      count <= {CW{1'b0}};
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem[i] <= 128'd0;
      end
    end else begin
      if (last) begin
        mem[wptr] <= fin;
        wptr      <= (wptr == LAST_PTR) ? {PW{1'b0}} : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == LAST_PTR) ? {PW{1'b0}} : rptr + PW'(1);
      end
      case ({last, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dpc_mk.sv
// tb_aes_dpc_mk: scoreboard bench for aes_dpc_mk using FIPS-197 vectors.
// The bench provides the S-box and the key schedule the core expects.
module tb_aes_dpc_mk;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_flag;
  logic [1:0]    i_klen;
  logic [1919:0] i_keyex;
  logic [127:0]  i_din;
  logic          i_din_valid;
  logic          o_din_ready;
  logic [127:0]  o_dout;
  logic          o_dout_valid;
  logic          i_dout_ready;
  logic          o_err;
  logic          o_busy;
  logic [127:0]  o_sbox_din;
  logic          o_sbox_inv;
  logic [127:0]  i_sbox_dout;

  always #5 clk = ~clk;

  aes_dpc_mk #(.OUT_DEPTH(2), .KLEN_EN(3'b111)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flag(i_flag), .i_klen(i_klen),
    .i_keyex(i_keyex), .i_din(i_din), .i_din_valid(i_din_valid),
    .o_din_ready(o_din_ready), .o_dout(o_dout), .o_dout_valid(o_dout_valid),
    .i_dout_ready(i_dout_ready), .o_err(o_err), .o_busy(o_busy),
    .o_sbox_din(o_sbox_din), .o_sbox_inv(o_sbox_inv), .i_sbox_dout(i_sbox_dout)
  );

  localparam logic [255:0] KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] data;
    int           t_acc;
    int           nr;
    logic         lat;
  } exp_t;

  exp_t         q[$];
  exp_t         mon_e;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [1919:0] kx128, kx192, kx256;

  always @(posedge clk) cyc <= cyc + 1;

  // combinational external S-box
  always_comb begin
    i_sbox_dout = 128'd0;
    for (int i = 0; i < 16; i++) begin
      i_sbox_dout[127-8*i -: 8] = o_sbox_inv ? isb[o_sbox_din[127-8*i -: 8]]
                                             : sb[o_sbox_din[127-8*i -: 8]];
    end
  end

  function automatic logic [7:0] bxt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] bmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = bxt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  // FIPS-197 key expansion. The core adds the round key before InvMixColumns
  // when decrypting, so the plain schedule words also serve for decryption.
  function automatic logic [1919:0] expand(input int nk, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [255:0]  k;
    logic [1919:0] kx;
    k  = KEY;
    rc = 8'h01;
    kx = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = bxt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) kx[1919-128*j -: 128] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return kx;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare every presented-and-taken output with the queue head
  always @(negedge clk) begin
    if (!i_rst && o_dout_valid && i_dout_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none", o_dout);
      end else begin
        mon_e = q.pop_front();
        chk("dout", o_dout, mon_e.data);
        if (mon_e.lat) chk("latency", 128'(cyc - mon_e.t_acc), 128'(mon_e.nr));
      end
    end
  end

  task automatic send(input logic [127:0] din, input logic flag, input logic [1:0] klen,
                      input logic [1919:0] kx, input logic [127:0] expv,
                      input logic push_it, input logic lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!o_din_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!o_din_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: ready got 0 expected 1");
      return;
    end
    i_din = din; i_flag = flag; i_klen = klen; i_keyex = kx; i_din_valid = 1'b1;
    if (push_it) begin
      e.data  = expv;
      e.t_acc = cyc + 1;
      e.nr    = (klen == 2'd0) ? 10 : (klen == 2'd1) ? 12 : 14;
      e.lat   = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 i_din_valid = 1'b0;
    if (klen != 2'd3) begin
      chk("busy", 128'(o_busy), 128'(1'b1));
      chk("sbox_inv", 128'(o_sbox_inv), 128'(!flag));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && bmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb[sb[x]] = 8'(x);
    kx128 = expand(4, 10);
    kx192 = expand(6, 12);
    kx256 = expand(8, 14);

    i_rst = 1'b1; i_flag = 1'b0; i_klen = 2'd0; i_keyex = '0; i_din = '0;
    i_din_valid = 1'b0; i_dout_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(o_dout_valid), 128'(1'b0));
    chk("rst_dout", o_dout, 128'd0);
    chk("rst_err", 128'(o_err), 128'(1'b0));
    chk("rst_busy", 128'(o_busy), 128'(1'b0));
    chk("rst_sbox_inv", 128'(o_sbox_inv), 128'(1'b0));
    chk("rst_sbox_din", o_sbox_din, 128'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;
    #1 chk("rst_ready", 128'(o_din_ready), 128'(1'b1));

    // encrypt and decrypt all three key lengths, consumer always ready
    send(PT, 1'b1, 2'd0, kx128, C128, 1'b1, 1'b1);
    send(PT, 1'b1, 2'd1, kx192, C192, 1'b1, 1'b1);
    send(PT, 1'b1, 2'd2, kx256, C256, 1'b1, 1'b1);
    drain();
    send(C128, 1'b0, 2'd0, kx128, PT, 1'b1, 1'b1);
    send(C192, 1'b0, 2'd1, kx192, PT, 1'b1, 1'b1);
    send(C256, 1'b0, 2'd2, kx256, PT, 1'b1, 1'b1);
    drain();

    // stalled consumer: two blocks fill the FIFO, the third waits for a pop
    @(posedge clk);
    #1 i_dout_ready = 1'b0;
    send(PT, 1'b1, 2'd0, kx128, C128, 1'b1, 1'b0);
    send(C128, 1'b0, 2'd0, kx128, PT, 1'b1, 1'b0);
    repeat (14) @(negedge clk);
    chk("full_ready", 128'(o_din_ready), 128'(1'b0));
    chk("full_valid", 128'(o_dout_valid), 128'(1'b1));
    chk("hold_head", o_dout, C128);
    repeat (3) @(negedge clk);
    chk("hold_head2", o_dout, C128);
    chk("full_ready2", 128'(o_din_ready), 128'(1'b0));
    @(posedge clk);
    #1 i_dout_ready = 1'b1;
    @(posedge clk);
    #1 i_dout_ready = 1'b0;
    chk("ready_after_pop", 128'(o_din_ready), 128'(1'b1));
    chk("head_after_pop", o_dout, PT);
    send(PT, 1'b1, 2'd0, kx128, C128, 1'b1, 1'b0);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 i_dout_ready = 1'b1;
    drain();

    // reserved key length is rejected with a single error pulse
    send(PT, 1'b1, 2'd3, kx128, 128'd0, 1'b0, 1'b0);
    chk("err_pulse", 128'(o_err), 128'(1'b1));
    chk("err_busy", 128'(o_busy), 128'(1'b0));
    chk("err_valid", 128'(o_dout_valid), 128'(1'b0));
    @(posedge clk);
    #1 chk("err_clear", 128'(o_err), 128'(1'b0));
    send(PT, 1'b1, 2'd0, kx128, C128, 1'b1, 1'b1);
    drain();

    // reset in round 5 with one result pending in the FIFO
    @(posedge clk);
    #1 i_dout_ready = 1'b0;
    send(PT, 1'b1, 2'd0, kx128, C128, 1'b0, 1'b0);
    repeat (12) @(posedge clk);
    #1 chk("pending_valid", 128'(o_dout_valid), 128'(1'b1));
    send(PT, 1'b1, 2'd2, kx256, C256, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    chk("mid_rst_valid", 128'(o_dout_valid), 128'(1'b0));
    chk("mid_rst_busy", 128'(o_busy), 128'(1'b0));
    chk("mid_rst_dout", o_dout, 128'd0);
    chk("mid_rst_ready", 128'(o_din_ready), 128'(1'b1));
    i_dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_err", 128'(o_err), 128'(1'b0));
    send(PT, 1'b1, 2'd2, kx256, C256, 1'b1, 1'b1);
    drain();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
